// File: rtl/btn_debounce_if.sv
// Pin-side bundle for btn_debounce: raw button levels in, conditioned levels and
// press/release events out. The slave modport is the conditioner's view.
interface btn_debounce_if #(
  parameter int N_BTN = 3
) ();
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_clean;
  logic [N_BTN-1:0] pressed;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;

  modport master (
    output btn_raw,
    input  btn_clean,
    input  pressed,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_clean,
    output pressed,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/btn_debounce.sv
// Per-channel push-button conditioner: 2-FF synchronizer, stability counter, clean level.
// Optional press/release pulses are built when BTN_DEBOUNCE_EVENTS_EN is defined.
module btn_debounce #(
  parameter int F_CLK_HZ       = 25_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int ACTIVE_LOW_BTN = 1,
  parameter int N_BTN          = 3
) (
  input  logic          clk,
  input  logic          rst,
  btn_debounce_if.slave bus
);

  localparam int DB_CALC  = (F_CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DB_TICKS = (DB_CALC < 1) ? 1 : DB_CALC;
  localparam int CW_CALC  = $clog2(DB_TICKS + 1);
  localparam int CW       = (CW_CALC < 1) ? 1 : CW_CALC;

  localparam logic [CW-1:0]    TERM  = CW'(DB_TICKS - 1);
  localparam logic             REL   = (ACTIVE_LOW_BTN != 0) ? 1'b1 : 1'b0;
  localparam logic [N_BTN-1:0] REL_V = {N_BTN{REL}};

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [N_BTN-1:0] stable;
  logic [CW-1:0]    cnt [N_BTN];
  logic [N_BTN-1:0] accept;

  // A channel is accepted on the edge where its mismatch has persisted DB_TICKS cycles.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_BTN; i++) begin
      accept[i] = (s2[i] != stable[i]) && (cnt[i] == TERM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= REL_V;
      s2     <= REL_V;
      stable <= REL_V;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= bus.btn_raw;
      s2 <= s1;
      for (int i = 0; i < N_BTN; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign bus.btn_clean = stable;
  assign bus.pressed   = stable ^ REL_V;

`ifdef BTN_DEBOUNCE_EVENTS_EN
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;

  // Accepted level away from REL is a press; back to REL is a release.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= accept & (s2 ^ REL_V);
      release_q <= accept & ~(s2 ^ REL_V);
    end
  end

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
`else
  assign bus.press_pulse   = '0;
  assign bus.release_pulse = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: an active-low and an active-high instance driven with mirrored
// pins, checked every cycle against a sample-window model plus directed timing points.
module tb_btn_debounce;
  localparam int F_CLK_HZ    = 8000;
  localparam int DEBOUNCE_MS = 1;
  localparam int DB          = 8;
  localparam int N           = 3;
`ifdef BTN_DEBOUNCE_EVENTS_EN
  localparam bit EV = 1'b1;
`else
  localparam bit EV = 1'b0;
`endif
  // Bits 2:0 belong to the active-low instance, bits 5:3 to the active-high one.
  localparam logic [5:0] REL6 = 6'b000_111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btn_debounce_if #(.N_BTN(N)) bus_lo ();
  btn_debounce_if #(.N_BTN(N)) bus_hi ();

  btn_debounce #(.F_CLK_HZ(F_CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS), .ACTIVE_LOW_BTN(1), .N_BTN(N))
    dut_lo (.clk(clk), .rst(rst), .bus(bus_lo));
  btn_debounce #(.F_CLK_HZ(F_CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS), .ACTIVE_LOW_BTN(0), .N_BTN(N))
    dut_hi (.clk(clk), .rst(rst), .bus(bus_hi));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pin sample pipeline, window of synchronized samples, accepted level.
  logic [5:0] p1, p2, acc, exp_press, exp_rel;
  logic [5:0] hist_q[$];
  int press_cnt[6];
  int rel_cnt[6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] obs_clean();   return {bus_hi.btn_clean, bus_lo.btn_clean};         endfunction
  function automatic logic [5:0] obs_pressed(); return {bus_hi.pressed, bus_lo.pressed};             endfunction
  function automatic logic [5:0] obs_press();   return {bus_hi.press_pulse, bus_lo.press_pulse};     endfunction
  function automatic logic [5:0] obs_rel();     return {bus_hi.release_pulse, bus_lo.release_pulse}; endfunction

  task automatic set_raw(input logic [2:0] v);
    bus_lo.btn_raw = v;
    bus_hi.btn_raw = ~v;
  endtask

  task automatic clear_counts();
    for (int b = 0; b < 6; b++) begin
      press_cnt[b] = 0;
      rel_cnt[b]   = 0;
    end
  endtask

  // One clock edge: advance the model with the inputs the DUT saw, then compare.
  task automatic step();
    logic [5:0] raw;
    logic all_diff;
    @(posedge clk);
    raw = {bus_hi.btn_raw, bus_lo.btn_raw};
    exp_press = '0;
    exp_rel   = '0;
    if (rst) begin
      p1 = REL6;
      p2 = REL6;
      acc = REL6;
      hist_q.delete();
    end else begin
      hist_q.push_back(p2);
      if (hist_q.size() > DB) void'(hist_q.pop_front());
      p2 = p1;
      p1 = raw;
      if (hist_q.size() == DB) begin
        for (int b = 0; b < 6; b++) begin
          all_diff = 1'b1;
          for (int k = 0; k < hist_q.size(); k++) begin
            if (hist_q[k][b] == acc[b]) all_diff = 1'b0;
          end
          if (all_diff) begin
            acc[b] = ~acc[b];
            if (acc[b] != REL6[b]) exp_press[b] = 1'b1;
            else                   exp_rel[b]   = 1'b1;
          end
        end
      end
    end
    #1;
    chk("clean", obs_clean(), acc);
    chk("pressed", obs_pressed(), acc ^ REL6);
    chk("press_pulse", obs_press(), EV ? exp_press : 6'b0);
    chk("release_pulse", obs_rel(), EV ? exp_rel : 6'b0);
    for (int b = 0; b < 6; b++) begin
      press_cnt[b] += int'(obs_press() >> b) & 1;
      rel_cnt[b]   += int'(obs_rel() >> b) & 1;
    end
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [2:0] v;
    clear_counts();
    p1 = REL6; p2 = REL6; acc = REL6;
    exp_press = '0; exp_rel = '0;

    // Reset with pins released, then 50 idle cycles
    rst = 1'b1;
    set_raw(3'b111);
    wait_n(3);
    rst = 1'b0;
    chk("reset_clean", obs_clean(), 6'b000_111);
    chk("reset_pressed", obs_pressed(), 6'b0);
    wait_n(50);
    chk("idle_pulses", press_cnt[0] + press_cnt[3] + rel_cnt[0] + rel_cnt[3], 0);

    // Clean press and release on channel A: accepted at edge 10
    clear_counts();
    set_raw(3'b110);
    wait_n(9);
    chk("press_edge9", obs_pressed(), 6'b0);
    step();
    chk("press_edge10", obs_pressed(), 6'b001_001);
    chk("press_pulse_edge10", obs_press(), EV ? 6'b001_001 : 6'b0);
    wait_n(20);
    set_raw(3'b111);
    wait_n(9);
    chk("release_edge9", obs_pressed(), 6'b001_001);
    step();
    chk("release_edge10", obs_clean(), 6'b000_111);
    chk("release_pulse_edge10", obs_rel(), EV ? 6'b001_001 : 6'b0);
    chk("clean_press_cnt", press_cnt[0] + press_cnt[3], EV ? 2 : 0);
    wait_n(5);

    // Glitch on B: 7 cycles rejected, 8 cycles accepted
    clear_counts();
    set_raw(3'b101);
    wait_n(7);
    set_raw(3'b111);
    wait_n(20);
    chk("glitch7_pressed", obs_pressed(), 6'b0);
    chk("glitch7_cnt", press_cnt[1] + press_cnt[4], 0);
    set_raw(3'b101);
    wait_n(8);
    set_raw(3'b111);
    wait_n(20);
    chk("glitch8_press_cnt", press_cnt[1] + press_cnt[4], EV ? 2 : 0);
    chk("glitch8_release_cnt", rel_cnt[1] + rel_cnt[4], EV ? 2 : 0);

    // Bounce on C: six toggles every 3 cycles, then held pressed
    clear_counts();
    v = 3'b111;
    for (int i = 0; i < 6; i++) begin
      v[2] = ~v[2];
      set_raw(v);
      wait_n(3);
    end
    set_raw(3'b011);
    wait_n(9);
    chk("bounce_edge9", obs_pressed(), 6'b0);
    step();
    chk("bounce_edge10", obs_pressed(), 6'b100_100);
    wait_n(5);
    chk("bounce_press_cnt", press_cnt[2] + press_cnt[5], EV ? 2 : 0);
    set_raw(3'b111);
    wait_n(12);

    // Simultaneous press on all channels, then reset in the middle of the release
    clear_counts();
    set_raw(3'b000);
    wait_n(9);
    step();
    chk("simul_press_pulse", obs_press(), EV ? 6'b111_111 : 6'b0);
    wait_n(5);
    set_raw(3'b111);
    wait_n(7);
    rst = 1'b1;
    set_raw(3'b000);
    wait_n(2);
    rst = 1'b0;
    chk("rst_mid_clean", obs_clean(), 6'b000_111);
    chk("rst_mid_pressed", obs_pressed(), 6'b0);
    wait_n(9);
    chk("reaccept_edge9", obs_pressed(), 6'b0);
    step();
    chk("reaccept_edge10", obs_pressed(), 6'b111_111);
    chk("reaccept_no_release", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3] + rel_cnt[4] + rel_cnt[5], 0);
    set_raw(3'b111);
    wait_n(12);

    // Randomized pins with occasional reset, checked against the model every cycle
    v = 3'b111;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) v[b] = ~v[b];
      end
      set_raw(v);
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    wait_n(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
